// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between the CPU
// load/store path (port C) and the program loader (port L), with bounded loader bursts.
module dmem_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  output logic          cpu_stall,
  input  logic          l_req,
  input  logic          l_lock,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_L = 1'b1
  } port_e;

  localparam int unsigned CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] BURST_LIM = CW'(BURST_MAX);

  port_e         last_grant_q, last_grant_d;
  port_e         rd_owner_q,   rd_owner_d;
  logic [CW-1:0] burst_cnt_q,  burst_cnt_d;
  logic          rd_pend_q,    rd_pend_d;
  logic          sel_c, sel_l;

  // Grant selection; forced low while reset is held so nothing reaches memory.
  always_comb begin
    sel_c = 1'b0;
    sel_l = 1'b0;
    if (rst) begin
      if (c_req && !l_req) begin
        sel_c = 1'b1;
      end else if (l_req && !c_req) begin
        sel_l = 1'b1;
      end else if (c_req && l_req) begin
        if (l_lock && (last_grant_q == PORT_L) && (burst_cnt_q < BURST_LIM)) begin
          sel_l = 1'b1;
        end else if (last_grant_q == PORT_L) begin
          sel_c = 1'b1;
        end else begin
          sel_l = 1'b1;
        end
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    rd_pend_d    = 1'b0;
    rd_owner_d   = rd_owner_q;

    if (sel_c) begin
      last_grant_d = PORT_C;
    end else if (sel_l) begin
      last_grant_d = PORT_L;
    end

    if (!l_lock || sel_c) begin
      burst_cnt_d = '0;
    end else if (sel_l && c_req && (burst_cnt_q != BURST_LIM)) begin
      burst_cnt_d = burst_cnt_q + CW'(1);
    end

    if (sel_c && !c_we) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = PORT_C;
    end else if (sel_l && !l_we) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = PORT_L;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= PORT_L;
      burst_cnt_q  <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= PORT_C;
    end else begin
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  always_comb begin
    c_gnt     = sel_c;
    l_gnt     = sel_l;
    cpu_stall = rst & c_req & ~sel_c;
    m_en      = sel_c | sel_l;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    if (sel_c) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (sel_l) begin
      m_we    = l_we;
      m_addr  = l_addr;
      m_wdata = l_wdata;
    end

    c_rvalid = rd_pend_q && (rd_owner_q == PORT_C);
    l_rvalid = rd_pend_q && (rd_owner_q == PORT_L);
    c_rdata  = c_rvalid ? m_rdata : '0;
    l_rdata  = l_rvalid ? m_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a small behavioural memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        c_req, c_we, l_req, l_lock, l_we;
  logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
  logic        c_gnt, c_rvalid, cpu_stall, l_gnt, l_rvalid, m_en, m_we;
  logic [31:0] c_rdata, l_rdata, m_addr, m_wdata, m_rdata;

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.AW(32), .DW(32), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .cpu_stall(cpu_stall),
    .l_req(l_req), .l_lock(l_lock), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    m_rdata = '0;
  end
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr[7:2]] <= m_wdata;
      else      m_rdata <= mem[m_addr[7:2]];
    end
  end

  typedef struct {
    logic        rst;
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        lr, lk, lw;
    logic [31:0] la, ld;
    logic        ecg, elg, ecv;
    logic [31:0] ecd;
    logic        elv;
    logic [31:0] eld;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic cr, logic cw, logic [31:0] ca, logic [31:0] cd,
                              logic lr, logic lk, logic lw, logic [31:0] la, logic [31:0] ld,
                              logic ecg, logic elg, logic ecv, logic [31:0] ecd,
                              logic elv, logic [31:0] eld);
    vec_t v;
    v.rst = r; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.lr = lr; v.lk = lk; v.lw = lw; v.la = la; v.ld = ld;
    v.ecg = ecg; v.elg = elg; v.ecv = ecv; v.ecd = ecd; v.elv = elv; v.eld = eld;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  logic        e_mwe;
  logic [31:0] e_maddr, e_mwd;

  initial begin
    rst = 1'b0; c_req = 1'b1; l_req = 1'b1; l_lock = 1'b0;
    c_we = 1'b0; l_we = 1'b0; c_addr = '0; l_addr = '0; c_wdata = '0; l_wdata = '0;

    // reset held with both requesting, then first grant goes to C
    add(0, 1,1,32'h30,32'h1,        1,0,1,32'h34,32'h2,        0,0, 0,0, 0,0);
    add(0, 1,1,32'h30,32'h1,        1,0,1,32'h34,32'h2,        0,0, 0,0, 0,0);
    add(1, 1,1,32'h30,32'h1,        1,0,1,32'h34,32'h2,        1,0, 0,0, 0,0);
    // CPU write then read of 0x10
    add(1, 1,1,32'h10,32'hDEADBEEF, 0,0,0,32'h0,32'h0,         1,0, 0,0, 0,0);
    add(1, 1,0,32'h10,32'h0,        0,0,0,32'h0,32'h0,         1,0, 0,0, 0,0);
    add(1, 0,0,32'h0,32'h0,         0,0,0,32'h0,32'h0,         0,0, 1,32'hDEADBEEF, 0,0);
    // loader alone, then strict alternation without lock
    add(1, 0,0,32'h0,32'h0,         1,0,1,32'h40,32'h11,       0,1, 0,0, 0,0);
    for (int i = 0; i < 6; i++)
      add(1, 1,1,32'h50,32'hC0,     1,0,1,32'h60,32'hA0,       (i % 2 == 0), (i % 2 == 1), 0,0, 0,0);
    // locked burst: C, then L x4, C, L, L
    add(1, 1,1,32'h50,32'hC0,       0,0,0,32'h0,32'h0,         1,0, 0,0, 0,0);
    for (int i = 0; i < 7; i++)
      add(1, 1,1,32'h50,32'hC0,     1,1,1,32'h60,32'hA0,       (i == 4), (i != 4), 0,0, 0,0);
    add(1, 1,1,32'h50,32'hC0,       1,0,1,32'h60,32'hA0,       1,0, 0,0, 0,0);
    // back-to-back reads C@0x4 then L@0x8
    add(1, 1,1,32'h4,32'h44444444,  0,0,0,32'h0,32'h0,         1,0, 0,0, 0,0);
    add(1, 0,0,32'h0,32'h0,         1,0,1,32'h8,32'h88888888,  0,1, 0,0, 0,0);
    add(1, 1,0,32'h4,32'h0,         0,0,0,32'h0,32'h0,         1,0, 0,0, 0,0);
    add(1, 0,0,32'h0,32'h0,         1,0,0,32'h8,32'h0,         0,1, 1,32'h44444444, 0,0);
    add(1, 0,0,32'h0,32'h0,         0,0,0,32'h0,32'h0,         0,0, 0,0, 1,32'h88888888);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst;
      c_req = vecs[i].cr; c_we = vecs[i].cw; c_addr = vecs[i].ca; c_wdata = vecs[i].cd;
      l_req = vecs[i].lr; l_lock = vecs[i].lk; l_we = vecs[i].lw;
      l_addr = vecs[i].la; l_wdata = vecs[i].ld;
      e_mwe   = vecs[i].ecg ? vecs[i].cw : (vecs[i].elg ? vecs[i].lw : 1'b0);
      e_maddr = vecs[i].ecg ? vecs[i].ca : (vecs[i].elg ? vecs[i].la : 32'h0);
      e_mwd   = vecs[i].ecg ? vecs[i].cd : (vecs[i].elg ? vecs[i].ld : 32'h0);
      @(negedge clk);
      chk($sformatf("v%0d c_gnt", i),     {31'b0, c_gnt},     {31'b0, vecs[i].ecg});
      chk($sformatf("v%0d l_gnt", i),     {31'b0, l_gnt},     {31'b0, vecs[i].elg});
      chk($sformatf("v%0d cpu_stall", i), {31'b0, cpu_stall},
          {31'b0, vecs[i].rst & vecs[i].cr & ~vecs[i].ecg});
      chk($sformatf("v%0d m_en", i),      {31'b0, m_en},      {31'b0, vecs[i].ecg | vecs[i].elg});
      chk($sformatf("v%0d m_we", i),      {31'b0, m_we},      {31'b0, e_mwe});
      chk($sformatf("v%0d m_addr", i),    m_addr,             e_maddr);
      chk($sformatf("v%0d m_wdata", i),   m_wdata,            e_mwd);
      chk($sformatf("v%0d c_rvalid", i),  {31'b0, c_rvalid},  {31'b0, vecs[i].ecv});
      chk($sformatf("v%0d c_rdata", i),   c_rdata,            vecs[i].ecd);
      chk($sformatf("v%0d l_rvalid", i),  {31'b0, l_rvalid},  {31'b0, vecs[i].elv});
      chk($sformatf("v%0d l_rdata", i),   l_rdata,            vecs[i].eld);
    end

    // loader read granted, then reset pulsed before its data returns
    @(posedge clk);
    #1;
    c_req = 1'b0; l_req = 1'b1; l_lock = 1'b0; l_we = 1'b0; l_addr = 32'h20;
    @(negedge clk);
    chk("rst_pulse l_gnt", {31'b0, l_gnt}, 32'h1);
    chk("rst_pulse m_addr", m_addr, 32'h20);
    @(posedge clk);
    #1;
    rst = 1'b0; c_req = 1'b1; l_req = 1'b1;
    #1;
    chk("in_rst l_rvalid", {31'b0, l_rvalid}, 32'h0);
    chk("in_rst grants", {30'b0, c_gnt, l_gnt}, 32'h0);
    chk("in_rst m_en", {31'b0, m_en}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1; c_we = 1'b1; c_addr = 32'h70; c_wdata = 32'h7; l_we = 1'b1; l_addr = 32'h74;
    @(negedge clk);
    chk("post_rst l_rvalid", {31'b0, l_rvalid}, 32'h0);
    chk("post_rst grants", {30'b0, c_gnt, l_gnt}, 32'h2);
    @(posedge clk);
    #1;
    c_req = 1'b0; l_req = 1'b0;
    @(negedge clk);
    chk("post_rst2 rvalid", {30'b0, c_rvalid, l_rvalid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
